// File: rtl/if_prefetch_stage_if.sv
// Fetch-stage bus bundle: instruction-memory read port, EX/interrupt redirect inputs and
// the decode-side valid/ready handshake. master = fetch stage, slave = its environment.
interface if_prefetch_stage_if;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        int_req;
  logic [31:0] entry_point;
  logic        id_ready;
  logic        id_valid;
  logic [31:0] id_ins;
  logic [31:0] id_pc;
  logic [31:0] id_pcp4;

  modport master (
    output imem_req, imem_addr, id_valid, id_ins, id_pc, id_pcp4,
    input  imem_rvalid, imem_rdata, redirect, redirect_pc, int_req, entry_point, id_ready
  );

  modport slave (
    input  imem_req, imem_addr, id_valid, id_ins, id_pc, id_pcp4,
    output imem_rvalid, imem_rdata, redirect, redirect_pc, int_req, entry_point, id_ready
  );
endinterface

// File: rtl/if_prefetch_stage.sv
// Instruction-fetch stage: owns the fetch PC, issues in-order imem reads into a DEPTH-entry
// prefetch queue feeding decode. Define IF_PERF_EN to add perf_fetched/perf_flushed counters.
module if_prefetch_stage #(
  parameter int          DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'd128
) (
  input  logic                clk,
  input  logic                rst_n,
  if_prefetch_stage_if.master bus
`ifdef IF_PERF_EN
  ,
  output logic [31:0]         perf_fetched,
  output logic [31:0]         perf_flushed
`endif
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);

  // pcp4 is stored rather than added at the head so every id_* output reads 0 out of reset
  typedef struct packed {
    logic [31:0] ins;
    logic [31:0] pc;
    logic [31:0] pcp4;
  } q_ent_t;

  q_ent_t [DEPTH-1:0] mem_q, mem_d;
  logic [PW-1:0]      rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
  logic [CW-1:0]      count_q, count_d, inflight_q, inflight_d, discard_q, discard_d;
  logic [31:0]        fetch_pc_q, fetch_pc_d, resp_pc_q, resp_pc_d;
  logic               flush, rsp_ok, issue, push, pop, vld;
  logic [31:0]        target;
  logic [CW:0]        occ;

  always_comb begin
    flush  = bus.int_req | bus.redirect;
    target = bus.int_req ? bus.entry_point : bus.redirect_pc;
    target[1:0] = 2'b00;
    // a response with nothing outstanding is a protocol error and is ignored
    rsp_ok = bus.imem_rvalid && (inflight_q != '0);
    // queued + in-flight words reserve a slot each, so a push always has room
    occ    = {1'b0, count_q} + {1'b0, inflight_q};
    issue  = !flush && (occ < (CW+1)'(DEPTH));
    push   = rsp_ok && !flush && (discard_q == '0);
    vld    = (count_q != '0) && !flush;
    pop    = vld && bus.id_ready;

    mem_d      = mem_q;
    rd_ptr_d   = rd_ptr_q;
    wr_ptr_d   = wr_ptr_q;
    count_d    = count_q;
    discard_d  = discard_q;
    fetch_pc_d = fetch_pc_q;
    resp_pc_d  = resp_pc_q;
    inflight_d = inflight_q + CW'(issue) - CW'(rsp_ok);

    if (flush) begin
      count_d    = '0;
      rd_ptr_d   = '0;
      wr_ptr_d   = '0;
      fetch_pc_d = target;
      resp_pc_d  = target;
      // everything still outstanding after this cycle's response belongs to the old stream
      discard_d  = inflight_q - CW'(rsp_ok);
    end else begin
      if (issue) fetch_pc_d = fetch_pc_q + 32'd4;
      if (rsp_ok && (discard_q != '0)) discard_d = discard_q - CW'(1);
      if (push) begin
        mem_d[wr_ptr_q] = '{ins: bus.imem_rdata, pc: resp_pc_q, pcp4: resp_pc_q + 32'd4};
        wr_ptr_d        = wr_ptr_q + PW'(1);
        resp_pc_d       = resp_pc_q + 32'd4;
      end
      if (pop) rd_ptr_d = rd_ptr_q + PW'(1);
      count_d = count_q + CW'(push) - CW'(pop);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_q      <= '0;
      rd_ptr_q   <= '0;
      wr_ptr_q   <= '0;
      count_q    <= '0;
      inflight_q <= '0;
      discard_q  <= '0;
      fetch_pc_q <= RESET_PC;
      resp_pc_q  <= RESET_PC;
    end else begin
      mem_q      <= mem_d;
      rd_ptr_q   <= rd_ptr_d;
      wr_ptr_q   <= wr_ptr_d;
      count_q    <= count_d;
      inflight_q <= inflight_d;
      discard_q  <= discard_d;
      fetch_pc_q <= fetch_pc_d;
      resp_pc_q  <= resp_pc_d;
    end
  end

  assign bus.imem_req  = rst_n && issue;
  assign bus.imem_addr = fetch_pc_q;
  assign bus.id_valid  = vld;
  assign bus.id_ins    = mem_q[rd_ptr_q].ins;
  assign bus.id_pc     = mem_q[rd_ptr_q].pc;
  assign bus.id_pcp4   = mem_q[rd_ptr_q].pcp4;

`ifdef IF_PERF_EN
  logic [31:0] fetched_q, fetched_d, flushed_q, flushed_d;
  logic [32:0] fl_sum;

  always_comb begin
    fetched_d = (push && (fetched_q != '1)) ? fetched_q + 32'd1 : fetched_q;
    // dropped responses plus whatever the flush throws out of the queue
    fl_sum    = {1'b0, flushed_q} + 33'(rsp_ok && !push) + (flush ? 33'(count_q) : 33'd0);
    flushed_d = fl_sum[32] ? 32'hFFFF_FFFF : fl_sum[31:0];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fetched_q <= '0;
      flushed_q <= '0;
    end else begin
      fetched_q <= fetched_d;
      flushed_q <= flushed_d;
    end
  end

  assign perf_fetched = fetched_q;
  assign perf_flushed = flushed_q;
`endif
endmodule

// File: tb/tb_if_prefetch_stage.sv
// Bench for if_prefetch_stage: in-order imem model with variable latency, and a reference
// model of the expected fetch-address and instruction streams with per-flush epochs.
module tb_if_prefetch_stage;
  localparam int DEPTH = 4;

  logic clk   = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  if_prefetch_stage_if bus();
`ifdef IF_PERF_EN
  logic [31:0] perf_fetched, perf_flushed;
`endif

  if_prefetch_stage #(.DEPTH(DEPTH), .RESET_PC(32'd128)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
`ifdef IF_PERF_EN
    ,
    .perf_fetched (perf_fetched),
    .perf_flushed (perf_flushed)
`endif
  );

  typedef struct {
    logic [31:0] addr;
    int          due;
    int          ep;
  } pend_t;

  pend_t       pend[$];
  int          n_chk, n_fail, cyc, ep, held, lat_lo, lat_hi, last_due;
  int          n_req, n_pop, first_req, first_vld, m_fetched, m_flushed;
  logic [31:0] exp_fetch, exp_pc;
  logic        s_req, s_vld;
  logic [31:0] s_addr, s_pc, s_pcp4;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    pend.delete();
    ep = 0; held = 0; last_due = 0; cyc = 0;
    exp_fetch = 32'h80; exp_pc = 32'h80;
    n_req = 0; n_pop = 0; first_req = -1; first_vld = -1;
    m_fetched = 0; m_flushed = 0;
  endtask

  task automatic drive_idle();
    bus.id_ready = 1'b0; bus.redirect = 1'b0; bus.redirect_pc = '0;
    bus.int_req = 1'b0; bus.entry_point = '0; bus.imem_rvalid = 1'b0; bus.imem_rdata = '0;
  endtask

  // Asserts reset away from a clock edge, checks outputs drop at once, releases at a negedge.
  task automatic do_reset();
    rst_n = 1'b0;
    drive_idle();
    #1;
    chk("rst_imem_req", bus.imem_req, 0);
    chk("rst_id_valid", bus.id_valid, 0);
    chk("rst_id_ins", bus.id_ins, 0);
    chk("rst_id_pc", bus.id_pc, 0);
    chk("rst_id_pcp4", bus.id_pcp4, 0);
`ifdef IF_PERF_EN
    chk("rst_perf_fetched", perf_fetched, 0);
    chk("rst_perf_flushed", perf_flushed, 0);
`endif
    @(negedge clk);
    @(negedge clk);
    model_reset();
    rst_n = 1'b1;
  endtask

  // One clock cycle: called at a negedge, drives inputs, samples, advances the model.
  task automatic step(input bit rdy, input bit redir, input logic [31:0] rpc,
                      input bit irq, input logic [31:0] epv);
    pend_t       got;
    bit          rsp, flush;
    logic [31:0] tgt;
    int          due;
    bus.id_ready = rdy; bus.redirect = redir; bus.redirect_pc = rpc;
    bus.int_req = irq; bus.entry_point = epv;
    rsp = 1'b0;
    if (pend.size() > 0 && pend[0].due <= cyc) begin
      got = pend.pop_front();
      rsp = 1'b1;
      bus.imem_rvalid = 1'b1;
      bus.imem_rdata  = mem_word(got.addr);
    end else begin
      bus.imem_rvalid = 1'b0;
      bus.imem_rdata  = $urandom;
    end
    #1;
    flush  = redir | irq;
    s_req  = bus.imem_req;  s_addr = bus.imem_addr;
    s_vld  = bus.id_valid;  s_pc   = bus.id_pc;  s_pcp4 = bus.id_pcp4;
    if (flush) begin
      chk("req_in_flush", s_req, 0);
      chk("vld_in_flush", s_vld, 0);
    end else begin
      chk("imem_req", s_req, 32'((held + pend.size() + int'(rsp)) < DEPTH));
      chk("id_valid", s_vld, 32'(held != 0));
      if (s_vld && first_vld < 0) first_vld = cyc;
      if (s_vld && rdy) begin
        chk("id_pc", s_pc, exp_pc);
        chk("id_ins", bus.id_ins, mem_word(exp_pc));
        chk("id_pcp4", s_pcp4, exp_pc + 32'd4);
        exp_pc += 32'd4;
        held--;
        n_pop++;
      end
      if (rsp) begin
        if (got.ep == ep) begin held++; m_fetched++; end
        else m_flushed++;
      end
    end
    if (s_req) begin
      chk("imem_addr", s_addr, exp_fetch);
      due = cyc + int'($urandom_range(lat_hi, lat_lo));
      if (due <= last_due) due = last_due + 1;
      last_due = due;
      pend.push_back('{addr: s_addr, due: due, ep: ep});
      exp_fetch += 32'd4;
      n_req++;
      if (first_req < 0) first_req = cyc;
    end
    if (flush) begin
      if (rsp) m_flushed++;
      m_flushed += held;
      tgt = irq ? epv : rpc;
      tgt[1:0] = 2'b00;
      exp_fetch = tgt; exp_pc = tgt; held = 0; ep++;
    end
    @(posedge clk);
    cyc++;
    @(negedge clk);
  endtask

  initial begin
    bit seen;
    n_chk = 0; n_fail = 0;
    lat_lo = 1; lat_hi = 1;
    drive_idle();
    #2;
    do_reset();

    // Latency-1 stream from the reset PC at full rate
    for (int i = 0; i < 8; i++) step(1, 0, 0, 0, 0);
    chk("t1_first_req_addr_cycle", 32'(first_req), 0);
    chk("t1_req_to_valid", 32'(first_vld - first_req), 2);
    chk("t1_rate", 32'(n_pop), 6);

    // Decode stalled: reservation caps outstanding reads at DEPTH
    do_reset();
    for (int i = 0; i < 10; i++) step(0, 0, 0, 0, 0);
    chk("t2_req_count", 32'(n_req), DEPTH);
    chk("t2_req_low", s_req, 0);
    for (int i = 0; i < 10; i++) step(1, 0, 0, 0, 0);
    chk("t2_drained_pc", exp_pc, 32'h80 + 32'(4 * n_pop));

    // Latency 3, redirect with reads in flight
    lat_lo = 3; lat_hi = 3;
    for (int i = 0; i < 20 && pend.size() < 2; i++) step(1, 0, 0, 0, 0);
    chk("t3_inflight_ge2", 32'(pend.size() >= 2), 1);
    step(1, 1, 32'h200, 0, 0);
    for (int i = 0; i < 20; i++) begin
      step(1, 0, 0, 0, 0);
      if (s_vld) break;
    end
    chk("t3_valid_seen", s_vld, 1);
    chk("t3_id_pc", s_pc, 32'h200);
    chk("t3_id_pcp4", s_pcp4, 32'h204);

    // Interrupt wins over a simultaneous redirect
    lat_lo = 1; lat_hi = 1;
    for (int i = 0; i < 6; i++) step(1, 0, 0, 0, 0);
    step(1, 1, 32'h300, 1, 32'h400);
    step(1, 0, 0, 0, 0);
    chk("t4_req", s_req, 1);
    chk("t4_addr", s_addr, 32'h400);

    // Misaligned target and address wrap
    step(1, 1, 32'h203, 0, 0);
    step(1, 0, 0, 0, 0);
    chk("t5_align_addr", s_addr, 32'h200);
    step(1, 1, 32'hFFFF_FFF8, 0, 0);
    seen = 1'b0;
    for (int i = 0; i < 10 && !seen; i++) begin
      step(1, 0, 0, 0, 0);
      if (s_req && s_addr == 32'h0) seen = 1'b1;
    end
    chk("t5_wrap_to_zero", 32'(seen), 1);
    for (int i = 0; i < 6; i++) step(1, 0, 0, 0, 0);

    // Randomized traffic: variable latency, stalls, back-to-back flushes
    lat_lo = 1; lat_hi = 4;
    for (int i = 0; i < 800; i++) begin
      bit r, f, q;
      r = ($urandom % 10) < 7;
      f = ($urandom % 20) == 0;
      q = ($urandom % 33) == 0;
      step(r, f, $urandom, q, $urandom);
    end
    chk("rand_progress", 32'(n_pop > 100), 1);
`ifdef IF_PERF_EN
    chk("perf_fetched", perf_fetched, 32'(m_fetched));
    chk("perf_flushed", perf_flushed, 32'(m_flushed));
`endif

    // Mid-stream reset and restart from the entry point
    do_reset();
    lat_lo = 1; lat_hi = 1;
    step(1, 0, 0, 0, 0);
    chk("t6_req", s_req, 1);
    chk("t6_addr", s_addr, 32'h80);
    for (int i = 0; i < 6; i++) step(1, 0, 0, 0, 0);
    chk("t6_restart_pc", exp_pc, 32'h80 + 32'(4 * n_pop));

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
